// File: rtl/rdy_vld_mem_fifo.sv
// -----------------------------------------------------------------------------
// rdy_vld_mem_fifo
//
// Streaming rdy/vld FIFO. Storage is a simple dual-port memory (write port A,
// registered read port B). A two-entry prefetch buffer at the output hides the
// one-cycle read latency, so the FIFO sustains one word per cycle. It also
// provides an occupancy count, almost-full/almost-empty watermarks and a
// synchronous flush.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all contents (memory data is kept)
//   in_vld       producer data valid
//   in_rdy       FIFO can accept a word
//   in_data      producer payload
//   out_vld      head word valid
//   out_rdy      consumer ready
//   out_data     head payload, stable while out_vld=1 and out_rdy=0
//   count        words held (memory + in-flight read + prefetch buffer)
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
// -----------------------------------------------------------------------------
module rdy_vld_mem_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage and read-port register (no reset so it maps onto block RAM).
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;   // words still in memory
    logic [CNT_W-1:0]  count_q, count_d;       // total words held
    logic              rd_vld_q, rd_vld_d;     // rd_data_q holds a word to capture
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              rdy_en_q;               // holds in_rdy low until reset is released

    logic              push;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        slots_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and read issue
    // ------------------------------------------------------------------
    assign in_rdy       = rdy_en_q && (count_q < CNT_W'(DEPTH)) && !flush;
    assign out_vld      = (buf_cnt_q != 2'd0);
    assign out_data     = buf_q[0];
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy && !flush;

    // Slots committed in the prefetch path after this cycle's pop. Crediting
    // the pop lets a read be issued every cycle while streaming, which is what
    // keeps the output free of bubbles; buffer + in-flight never exceeds 2.
    assign slots_used = 3'(buf_cnt_q) + 3'(rd_vld_q) - 3'(pop);
    assign rd_issue   = !flush && (mem_cnt_q != '0) && (slots_used < 3'd2);

    // ------------------------------------------------------------------
    // Memory: write port A, registered read port B
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        count_d   = count_q;
        rd_vld_d  = rd_vld_q;
        buf_cnt_d = buf_cnt_q;
        buf_d[0]  = buf_q[0];
        buf_d[1]  = buf_q[1];

        if (flush) begin
            // The in-flight read is dropped by clearing rd_vld; buffer data
            // words are left as-is since buf_cnt marks them invalid.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            mem_cnt_d = '0;
            count_d   = '0;
            rd_vld_d  = 1'b0;
            buf_cnt_d = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_issue) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            mem_cnt_d = mem_cnt_q + CNT_W'(push) - CNT_W'(rd_issue);
            count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_vld_d  = rd_issue;

            // Buffer is a two-deep shift queue with the head in entry 0.
            // A capture without a pop only happens with 0 or 1 entries held.
            case ({pop, rd_vld_q})
                2'b01: begin
                    buf_d[buf_cnt_q[0]] = rd_data_q;
                    buf_cnt_d           = buf_cnt_q + 2'd1;
                end
                2'b10: begin
                    buf_d[0]  = buf_q[1];
                    buf_cnt_d = buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf_d[0] = rd_data_q;
                    end else begin
                        buf_d[0] = buf_q[1];
                        buf_d[1] = rd_data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            count_q   <= '0;
            rd_vld_q  <= 1'b0;
            buf_cnt_q <= 2'd0;
            rdy_en_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            buf_cnt_q <= buf_cnt_d;
            rdy_en_q  <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                buf_q[gi] <= '0;
            end else begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    end

endmodule
